pipe_hazard_ctrl: RTL

- Central hazard controller for the pipelined LC-3b datapath.
- Generates the per-stage `stall` and `flush` controls that the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers consume, plus the PC hold/redirect controls.
- Covers four hazard sources: data-cache wait, instruction-cache wait, load-use dependency, and taken control transfer resolved in MEM.
- Tracks in-flight fetches that must be discarded after a redirect, and keeps a saturating stall-cycle counter for performance analysis.

---
 rtl/pipe_hazard_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Purpose: central hazard controller producing per-stage stall/flush and PC hold/redirect for the LC-3b pipeline.
// Latency: controls are combinational from inputs and registered state (zero-cycle decision); state and counter update on clk.
// Backpressure: cache waits hold the PC (and the whole pipe for data-cache waits); redirects squash younger slots instead of stalling.
module pipe_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             icache_req,
    input  logic             icache_resp,
    input  logic             dcache_req,
    input  logic             dcache_resp,
    input  logic             ex_is_load,
    input  logic [2:0]       ex_dr,
    input  logic [2:0]       id_sr1,
    input  logic [2:0]       id_sr2,
    input  logic             id_sr1_used,
    input  logic             id_sr2_used,
    input  logic             mem_br_taken,
    input  logic             perf_clear,
    output logic             pc_stall,
    output logic             load_pc_target,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             stall_ex_mem,
    output logic             stall_mem_wb,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic [CNT_W-1:0] stall_count
);

    // DISCARD means a fetch issued before a redirect is still in flight and
    // its response must be dropped rather than decoded.
    typedef enum logic {
        RUN     = 1'b0,
        DISCARD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t state;
    state_t state_nxt;

    logic dmem_wait;
    logic imem_wait;
    logic sr1_hit;
    logic sr2_hit;
    logic load_use;

    // Hazard source decode.
    always_comb begin
        dmem_wait = dcache_req & ~dcache_resp;
        imem_wait = icache_req & ~icache_resp;
        sr1_hit   = id_sr1_used & (id_sr1 == ex_dr);
        sr2_hit   = id_sr2_used & (id_sr2 == ex_dr);
        load_use  = ex_is_load & (sr1_hit | sr2_hit);
    end

    // Prioritised control decode and discard-tracking next state.
    always_comb begin
        pc_stall       = 1'b0;
        load_pc_target = 1'b0;
        stall_if_id    = 1'b0;
        stall_id_ex    = 1'b0;
        stall_ex_mem   = 1'b0;
        stall_mem_wb   = 1'b0;
        flush_if_id    = 1'b0;
        flush_id_ex    = 1'b0;
        flush_ex_mem   = 1'b0;
        state_nxt      = state;

        // A stale fetch response retires the discard whatever case wins,
        // including while the data cache is holding the whole pipe.
        if ((state == DISCARD) && icache_resp) begin
            state_nxt = RUN;
        end

        if (dmem_wait) begin
            // Freeze everything; a pending redirect waits for the completing cycle.
            pc_stall     = 1'b1;
            stall_if_id  = 1'b1;
            stall_id_ex  = 1'b1;
            stall_ex_mem = 1'b1;
            stall_mem_wb = 1'b1;
        end else if (mem_br_taken) begin
            load_pc_target = 1'b1;
            flush_if_id    = 1'b1;
            flush_id_ex    = 1'b1;
            flush_ex_mem   = 1'b1;
            if (imem_wait) begin
                state_nxt = DISCARD;
            end
        end else if (imem_wait || (state == DISCARD)) begin
            // Bubble into decode while older instructions keep draining.
            pc_stall    = 1'b1;
            flush_if_id = 1'b1;
        end else if (load_use) begin
            pc_stall    = 1'b1;
            stall_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end
    end

    // Discard-tracking state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Saturating count of PC-hold cycles; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (perf_clear) begin
            stall_count <= '0;
        end else if (pc_stall && (stall_count != CNT_MAX)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule
